// File: rtl/itch_axil_snapshot_master.sv
// AXI4-Lite read-only master: fetches one ITCH message snapshot (LATCHED_VALID
// plus 12 field words) from the parser register block and presents it as one record.
module itch_axil_snapshot_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 7,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_BASE_ADDR        = 0,
  parameter int unsigned C_TIMEOUT          = 255
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  input  logic                          start,
  input  logic                          clr_err,
  output logic                          busy,
  output logic                          no_data,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [3:0]                    rec_type,
  output logic [63:0]                   rec_order_ref,
  output logic                          rec_side,
  output logic [31:0]                   rec_shares,
  output logic [31:0]                   rec_price,
  output logic [63:0]                   rec_new_order_ref,
  output logic [47:0]                   rec_timestamp,
  output logic [63:0]                   rec_misc,
  output logic                          rec_err,
  output logic                          err_resp,
  output logic                          err_timeout
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned TW = $clog2(C_TIMEOUT + 32'd1);
  localparam logic [TW-1:0] TO_ONE  = TW'(32'd1);
  localparam logic [TW-1:0] TO_LAST = TW'(C_TIMEOUT - 32'd1);
  localparam logic [TW-1:0] TO_MAX  = TW'(C_TIMEOUT);
  localparam logic [3:0]    LAST_IDX = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  state_e        state_q;
  logic [3:0]    idx_q;
  logic [AW-1:0] araddr_q;
  logic          arvalid_q;
  logic          rready_q;
  logic          busy_q;
  logic          no_data_q;
  logic          rec_valid_q;
  logic          rec_err_q;
  logic          err_resp_q;
  logic          err_timeout_q;
  logic [3:0]    type_q;
  logic [63:0]   order_ref_q;
  logic          side_q;
  logic [31:0]   shares_q;
  logic [31:0]   price_q;
  logic [63:0]   new_ref_q;
  logic [47:0]   ts_q;
  logic [63:0]   misc_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [TW-1:0] tmo_cnt_d;

  logic ar_hs_s;
  logic r_hs_s;
  logic stall_s;
  logic resp_err_s;
  logic tmo_hit_s;

  // Word index 0 is LATCHED_VALID at offset 0x08; fields follow at 4-byte steps.
  function automatic logic [AW-1:0] word_addr(input logic [3:0] idx);
    logic [31:0] byte_addr;
    byte_addr = C_BASE_ADDR + 32'd8 + {26'd0, idx, 2'b00};
    return byte_addr[AW-1:0];
  endfunction

  // Handshake decode and stall-timeout counter next state.
  always_comb begin
    ar_hs_s    = (state_q == ST_AR) && M_AXI_ARREADY;
    r_hs_s     = (state_q == ST_R) && M_AXI_RVALID;
    stall_s    = ((state_q == ST_AR) && !M_AXI_ARREADY) ||
                 ((state_q == ST_R) && !M_AXI_RVALID);
    resp_err_s = r_hs_s && (M_AXI_RRESP != 2'b00);
    tmo_hit_s  = stall_s && (tmo_cnt_q == TO_LAST);
    tmo_cnt_d  = tmo_cnt_q;
    if (stall_s) begin
      if (tmo_cnt_q != TO_MAX) begin
        tmo_cnt_d = tmo_cnt_q + TO_ONE;
      end else begin
        tmo_cnt_d = tmo_cnt_q;
      end
    end else if (ar_hs_s || r_hs_s) begin
      tmo_cnt_d = {TW{1'b0}};
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Snapshot FSM with registered AXI, status and record outputs.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q       <= ST_IDLE;
      idx_q         <= 4'd0;
      araddr_q      <= {AW{1'b0}};
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      busy_q        <= 1'b0;
      no_data_q     <= 1'b0;
      rec_valid_q   <= 1'b0;
      rec_err_q     <= 1'b0;
      err_resp_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      type_q        <= 4'd0;
      order_ref_q   <= 64'd0;
      side_q        <= 1'b0;
      shares_q      <= 32'd0;
      price_q       <= 32'd0;
      new_ref_q     <= 64'd0;
      ts_q          <= 48'd0;
      misc_q        <= 64'd0;
      tmo_cnt_q     <= {TW{1'b0}};
    end else begin
      no_data_q <= 1'b0;
      tmo_cnt_q <= tmo_cnt_d;

      // A set event in the same cycle wins over clr_err.
      if (resp_err_s) begin
        err_resp_q <= 1'b1;
      end else if (clr_err) begin
        err_resp_q <= 1'b0;
      end
      if (tmo_hit_s) begin
        err_timeout_q <= 1'b1;
      end else if (clr_err) begin
        err_timeout_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_AR;
            idx_q     <= 4'd0;
            araddr_q  <= word_addr(4'd0);
            arvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            rec_err_q <= 1'b0;
          end
        end
        ST_AR: begin
          if (ar_hs_s) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_R;
          end
        end
        ST_R: begin
          if (r_hs_s) begin
            rready_q <= 1'b0;
            if (resp_err_s) begin
              rec_err_q <= 1'b1;
            end
            case (idx_q)
              4'd1:    type_q              <= M_AXI_RDATA[3:0];
              4'd2:    order_ref_q[31:0]   <= M_AXI_RDATA[31:0];
              4'd3:    order_ref_q[63:32]  <= M_AXI_RDATA[31:0];
              4'd4:    side_q              <= M_AXI_RDATA[0];
              4'd5:    shares_q            <= M_AXI_RDATA[31:0];
              4'd6:    price_q             <= M_AXI_RDATA[31:0];
              4'd7:    new_ref_q[31:0]     <= M_AXI_RDATA[31:0];
              4'd8:    new_ref_q[63:32]    <= M_AXI_RDATA[31:0];
              4'd9:    ts_q[31:0]          <= M_AXI_RDATA[31:0];
              4'd10:   ts_q[47:32]         <= M_AXI_RDATA[15:0];
              4'd11:   misc_q[31:0]        <= M_AXI_RDATA[31:0];
              4'd12:   misc_q[63:32]       <= M_AXI_RDATA[31:0];
              default: ;
            endcase
            if ((idx_q == 4'd0) && !M_AXI_RDATA[0]) begin
              no_data_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end else if (idx_q == LAST_IDX) begin
              rec_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
            end else begin
              idx_q     <= idx_q + 4'd1;
              araddr_q  <= word_addr(idx_q + 4'd1);
              arvalid_q <= 1'b1;
              state_q   <= ST_AR;
            end
          end
        end
        ST_HOLD: begin
          if (rec_ready) begin
            rec_valid_q <= 1'b0;
            rec_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          arvalid_q   <= 1'b0;
          rready_q    <= 1'b0;
          rec_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign M_AXI_ARADDR      = araddr_q;
  assign M_AXI_ARPROT      = 3'b000;
  assign M_AXI_ARVALID     = arvalid_q;
  assign M_AXI_RREADY      = rready_q;
  assign busy              = busy_q;
  assign no_data           = no_data_q;
  assign rec_valid         = rec_valid_q;
  assign rec_type          = type_q;
  assign rec_order_ref     = order_ref_q;
  assign rec_side          = side_q;
  assign rec_shares        = shares_q;
  assign rec_price         = price_q;
  assign rec_new_order_ref = new_ref_q;
  assign rec_timestamp     = ts_q;
  assign rec_misc          = misc_q;
  assign rec_err           = rec_err_q;
  assign err_resp          = err_resp_q;
  assign err_timeout       = err_timeout_q;

endmodule

// File: tb/tb_itch_axil_snapshot_master.sv
// Directed bench for itch_axil_snapshot_master against a small AXI4-Lite
// register-slave model with programmable ARREADY/RVALID delays and SLVERR injection.
module tb_itch_axil_snapshot_master;

  logic         clk;
  logic         rst_n;
  logic [6:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic         start;
  logic         clr_err;
  logic         busy;
  logic         no_data;
  logic         rec_valid;
  logic         rec_ready;
  logic [3:0]   rec_type;
  logic [63:0]  rec_order_ref;
  logic         rec_side;
  logic [31:0]  rec_shares;
  logic [31:0]  rec_price;
  logic [63:0]  rec_new_order_ref;
  logic [47:0]  rec_timestamp;
  logic [63:0]  rec_misc;
  logic         rec_err;
  logic         err_resp;
  logic         err_timeout;

  itch_axil_snapshot_master #(
    .C_M_AXI_ADDR_WIDTH(7),
    .C_M_AXI_DATA_WIDTH(32),
    .C_BASE_ADDR(0),
    .C_TIMEOUT(16)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESETN(rst_n),
    .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata),
    .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready),
    .start(start),
    .clr_err(clr_err),
    .busy(busy),
    .no_data(no_data),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_type(rec_type),
    .rec_order_ref(rec_order_ref),
    .rec_side(rec_side),
    .rec_shares(rec_shares),
    .rec_price(rec_price),
    .rec_new_order_ref(rec_new_order_ref),
    .rec_timestamp(rec_timestamp),
    .rec_misc(rec_misc),
    .rec_err(rec_err),
    .err_resp(err_resp),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model state
  logic [31:0] mem [0:15];
  int          ar_dly = 0;
  int          r_dly = 0;
  logic [6:0]  err_addr = 7'h7F;
  logic [6:0]  tmo_addr = 7'h7F;
  int          ar_cnt;
  int          r_cnt;
  logic        r_pend;
  logic [7:0]  n_rd = 8'd0;
  logic [6:0]  addr_log [0:255];
  logic [6:0]  s_off;
  logic [3:0]  s_idx;
  int          ar_dly_eff;

  assign s_off = araddr - 7'd8;
  assign s_idx = s_off[5:2];
  assign ar_dly_eff = (araddr == tmo_addr) ? 19 : ar_dly;

  // Register-slave: delayed ARREADY, delayed RVALID, data from mem.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= 32'd0;
      rresp   <= 2'b00;
      ar_cnt  <= 0;
      r_cnt   <= 0;
      r_pend  <= 1'b0;
    end else begin
      if (arvalid && arready) begin
        arready          <= 1'b0;
        ar_cnt           <= 0;
        addr_log[n_rd]   <= araddr;
        n_rd             <= n_rd + 8'd1;
        rdata            <= mem[s_idx];
        rresp            <= (araddr == err_addr) ? 2'b10 : 2'b00;
        if (r_dly == 0) begin
          rvalid <= 1'b1;
        end else begin
          r_cnt  <= r_dly;
          r_pend <= 1'b1;
        end
      end else if (arvalid && !arready) begin
        if (ar_cnt >= ar_dly_eff) arready <= 1'b1;
        else ar_cnt <= ar_cnt + 1;
      end
      if (r_pend) begin
        if (r_cnt == 1) begin
          rvalid <= 1'b1;
          r_pend <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1;
        end
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // Protocol watchers: AR stability while stalled, record stability in HOLD.
  logic         ar_stall_e;
  logic [6:0]   ar_addr_e;
  logic         rdy_e;
  logic         rv_prev = 1'b0;
  logic [308:0] rec_cat;
  logic [308:0] rec_prev;
  int           ar_viol = 0;
  int           hold_viol = 0;

  assign rec_cat = {rec_type, rec_order_ref, rec_side, rec_shares, rec_price,
                    rec_new_order_ref, rec_timestamp, rec_misc};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_stall_e <= 1'b0;
      ar_addr_e  <= 7'd0;
      rdy_e      <= 1'b0;
    end else begin
      ar_stall_e <= arvalid && !arready;
      ar_addr_e  <= araddr;
      rdy_e      <= rec_valid && rec_ready;
    end
  end

  always @(negedge clk) begin
    if (rst_n && ar_stall_e && (!arvalid || (araddr != ar_addr_e))) ar_viol <= ar_viol + 1;
    if (rst_n && rv_prev && rec_valid && (rec_cat != rec_prev)) hold_viol <= hold_viol + 1;
    if (rst_n && rv_prev && !rec_valid && !rdy_e) hold_viol <= hold_viol + 1;
    rv_prev  <= rst_n && rec_valid;
    rec_prev <= rec_cat;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] t, o_lo, o_hi, s, sh, pr, n_lo, n_hi,
                      ts_lo, ts_hi, m_lo, m_hi);
    mem[0] = 32'd1;   mem[1] = t;      mem[2] = o_lo;   mem[3] = o_hi;
    mem[4] = s;       mem[5] = sh;     mem[6] = pr;     mem[7] = n_lo;
    mem[8] = n_hi;    mem[9] = ts_lo;  mem[10] = ts_hi; mem[11] = m_lo;
    mem[12] = m_hi;
  endtask

  task automatic check_record(input string tag, input logic [3:0] t, input logic [63:0] o,
                              input logic s, input logic [31:0] sh, input logic [31:0] pr,
                              input logic [63:0] n, input logic [47:0] ts, input logic [63:0] m);
    check_eq({tag, ".type"}, rec_type, t);
    check_eq({tag, ".order_ref"}, rec_order_ref, o);
    check_eq({tag, ".side"}, rec_side, s);
    check_eq({tag, ".shares"}, rec_shares, sh);
    check_eq({tag, ".price"}, rec_price, pr);
    check_eq({tag, ".new_ref"}, rec_new_order_ref, n);
    check_eq({tag, ".timestamp"}, rec_timestamp, ts);
    check_eq({tag, ".misc"}, rec_misc, m);
  endtask

  task automatic check_nominal(input string tag);
    check_record(tag, 4'd3, 64'h0000_0001_2345_6789, 1'b1, 32'd100, 32'd1000500,
                 64'd0, 48'h0123_4567_89AB, 64'd0);
  endtask

  task automatic check_alt(input string tag);
    check_record(tag, 4'd7, 64'h89AB_CDEF_0123_4567, 1'b0, 32'h0000_1234, 32'h0000_5678,
                 64'h1111_2222_3333_4444, 48'hCAFE_DEAD_BEEF, 64'h5555_6666_7777_8888);
  endtask

  task automatic load_nominal();
    load(32'd3, 32'h2345_6789, 32'h1, 32'd1, 32'd100, 32'd1000500, 32'd0, 32'd0,
         32'h4567_89AB, 32'h0000_0123, 32'd0, 32'd0);
  endtask

  task automatic load_alt();
    load(32'h0000_0007, 32'h0123_4567, 32'h89AB_CDEF, 32'hFFFF_FFFE, 32'h0000_1234,
         32'h0000_5678, 32'h3333_4444, 32'h1111_2222, 32'hDEAD_BEEF, 32'hFFFF_CAFE,
         32'h7777_8888, 32'h5555_6666);
  endtask

  // Called at a negedge; returns at the negedge after start was sampled.
  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rec(input string tag, output int lat);
    lat = 0;
    while (!rec_valid && lat < 400) begin
      @(negedge clk);
      lat = lat + 1;
    end
    check_eq({tag, ".rec_valid_seen"}, rec_valid, 1'b1);
  endtask

  task automatic accept(input string tag, input int hold);
    repeat (hold) @(negedge clk);
    rec_ready = 1'b1;
    @(negedge clk);
    rec_ready = 1'b0;
    check_eq({tag, ".rec_valid_drop"}, rec_valid, 1'b0);
    check_eq({tag, ".busy_drop"}, busy, 1'b0);
  endtask

  task automatic wait_addr(input string tag, input logic [6:0] a);
    int k;
    k = 0;
    while (!(arvalid && araddr == a) && k < 300) begin
      @(negedge clk);
      k = k + 1;
    end
    check_eq({tag, ".reach_addr"}, (arvalid && araddr == a), 1'b1);
  endtask

  initial begin
    int lat;
    int nd_cnt;
    int rv_cnt;
    logic nd_busy;
    logic [7:0] base;
    logic [7:0] d;

    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    rst_n = 1'b0;
    start = 1'b0;
    clr_err = 1'b0;
    rec_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst.arvalid", arvalid, 1'b0);
    check_eq("rst.araddr", araddr, 7'd0);
    check_eq("rst.rready", rready, 1'b0);
    check_eq("rst.busy", busy, 1'b0);
    check_eq("rst.rec_valid", rec_valid, 1'b0);
    check_eq("rst.order_ref", rec_order_ref, 64'd0);
    check_eq("rst.errs", {err_resp, err_timeout, rec_err, no_data}, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst.arprot", arprot, 3'b000);

    // Nominal snapshot with single-cycle slave
    load_nominal();
    base = n_rd;
    kick();
    check_eq("nom.arvalid_rise", arvalid, 1'b1);
    check_eq("nom.busy_rise", busy, 1'b1);
    check_eq("nom.first_addr", araddr, 7'h08);
    wait_rec("nom", lat);
    check_eq("nom.latency", lat, 39);
    for (int i = 0; i < 13; i++) begin
      check_eq($sformatf("nom.addr%0d", i), addr_log[base + 8'(i)], 7'(8 + 4 * i));
    end
    check_nominal("nom");
    check_eq("nom.rec_err", rec_err, 1'b0);
    accept("nom", 4);
    check_eq("nom.err_timeout", err_timeout, 1'b0);

    // No data
    mem[0] = 32'hFFFF_FFFE;
    base = n_rd;
    nd_cnt = 0;
    rv_cnt = 0;
    nd_busy = 1'b1;
    kick();
    for (int i = 0; i < 20; i++) begin
      if (no_data) begin
        nd_cnt = nd_cnt + 1;
        nd_busy = busy;
      end
      if (rec_valid) rv_cnt = rv_cnt + 1;
      @(negedge clk);
    end
    d = n_rd - base;
    check_eq("nodata.reads", d, 8'd1);
    check_eq("nodata.addr", addr_log[base], 7'h08);
    check_eq("nodata.pulses", nd_cnt, 1);
    check_eq("nodata.busy_at_pulse", nd_busy, 1'b0);
    check_eq("nodata.rec_valid", rv_cnt, 0);
    check_eq("nodata.busy", busy, 1'b0);

    // Backpressure, junk in the ignored upper bits
    load(32'hABCD_0003, 32'h2345_6789, 32'h1, 32'hFFFF_FFFF, 32'd100, 32'd1000500,
         32'd0, 32'd0, 32'h4567_89AB, 32'h5A5A_0123, 32'd0, 32'd0);
    ar_dly = 5;
    r_dly = 3;
    base = n_rd;
    kick();
    wait_rec("bp", lat);
    d = n_rd - base;
    check_eq("bp.reads", d, 8'd13);
    check_nominal("bp");
    accept("bp", 10);
    check_eq("bp.ar_stable", ar_viol, 0);
    check_eq("bp.hold_stable", hold_viol, 0);
    check_eq("bp.err_timeout", err_timeout, 1'b0);
    ar_dly = 0;
    r_dly = 0;

    // Timeout on 0x1C with C_TIMEOUT=16
    load_nominal();
    tmo_addr = 7'h1C;
    base = n_rd;
    kick();
    wait_addr("tmo", 7'h1C);
    repeat (15) @(negedge clk);
    check_eq("tmo.before16", err_timeout, 1'b0);
    @(negedge clk);
    check_eq("tmo.at16", err_timeout, 1'b1);
    check_eq("tmo.arvalid_held", arvalid, 1'b1);
    check_eq("tmo.araddr_held", araddr, 7'h1C);
    wait_rec("tmo", lat);
    d = n_rd - base;
    check_eq("tmo.reads", d, 8'd13);
    check_nominal("tmo");
    accept("tmo", 0);
    check_eq("tmo.sticky", err_timeout, 1'b1);
    check_eq("tmo.ar_stable", ar_viol, 0);
    tmo_addr = 7'h7F;

    // SLVERR on PRICE
    load_alt();
    err_addr = 7'h20;
    base = n_rd;
    kick();
    wait_rec("resp", lat);
    d = n_rd - base;
    check_eq("resp.reads", d, 8'd13);
    check_eq("resp.rec_err", rec_err, 1'b1);
    check_eq("resp.err_resp", err_resp, 1'b1);
    check_alt("resp");
    accept("resp", 2);
    check_eq("resp.sticky", err_resp, 1'b1);
    check_eq("resp.rec_err_clr", rec_err, 1'b0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check_eq("clr.err_resp", err_resp, 1'b0);
    check_eq("clr.err_timeout", err_timeout, 1'b0);
    err_addr = 7'h7F;

    // Clean snapshot after clearing
    load_nominal();
    kick();
    wait_rec("clean", lat);
    check_eq("clean.rec_err", rec_err, 1'b0);
    check_eq("clean.err_resp", err_resp, 1'b0);
    accept("clean", 0);

    // Asynchronous reset during the read of 0x18
    load_alt();
    ar_dly = 3;
    kick();
    wait_addr("mrst", 7'h18);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mrst.arvalid", arvalid, 1'b0);
    check_eq("mrst.rready", rready, 1'b0);
    check_eq("mrst.busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ar_dly = 0;
    @(negedge clk);
    base = n_rd;
    kick();
    check_eq("mrst.restart_addr", araddr, 7'h08);
    check_eq("mrst.restart_arvalid", arvalid, 1'b1);
    wait_rec("mrst", lat);
    check_eq("mrst.latency", lat, 39);
    d = n_rd - base;
    check_eq("mrst.reads", d, 8'd13);
    check_alt("mrst");
    accept("mrst", 0);
    check_eq("final.ar_stable", ar_viol, 0);
    check_eq("final.hold_stable", hold_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
